gf_poly_eval: RTL and testbench

- Sequential Horner evaluator over GF(2^SIZE).
- Consumes a flat coefficient vector of degree n, in the format gf_poly_add produces on flat_z, plus an evaluation point x. Returns y = p(x).
- Sits directly downstream of gf_poly_add in the RS datapath and is reused for syndrome and error-locator evaluation.
- Uses one combinational GF multiplier, reduced by PRIM, once per cycle. It has a valid/ready handshake on both sides.

---
 rtl/gf_poly_eval.sv | 110 +++++++++++
 tb/tb_gf_poly_eval.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/gf_poly_eval.sv
// Sequential Horner evaluator over GF(2^SIZE): y = p(x), one multiply per cycle.
// Coefficients come flat with c_0 in the LSBs, the same layout gf_poly_add emits.
module gf_poly_eval #(
  parameter int              m         = 255,
  parameter int              SIZE      = $clog2(m),
  parameter int              n         = 2,
  parameter int              flat_size = (n+1)*SIZE,
  parameter logic [SIZE:0]   PRIM      = 9'h11D
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [flat_size-1:0] flat_p,
  input  logic [SIZE-1:0]      x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SIZE-1:0]      y
);

  localparam int IW = ($clog2(n+1) < 1) ? 1 : $clog2(n+1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                  state_q, state_d;
  logic [SIZE-1:0]         acc_q, acc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [n:0][SIZE-1:0]    coef_q, coef_d;
  logic [SIZE-1:0]         x_q, x_d;
  logic [SIZE-1:0]         y_q, y_d;
  logic                    out_valid_q, out_valid_d;
  logic [SIZE-1:0]         horner;

  // Carry-less product, then fold bits SIZE.. back down with PRIM from the top.
  function automatic logic [SIZE-1:0] gf_mul(input logic [SIZE-1:0] a,
                                             input logic [SIZE-1:0] b);
    logic [2*SIZE-2:0] p;
    p = '0;
    for (int i = 0; i < SIZE; i++)
      if (b[i]) p = p ^ ({{(SIZE-1){1'b0}}, a} << i);
    for (int k = 2*SIZE-2; k >= SIZE; k--)
      if (p[k]) p = p ^ ({{(SIZE-2){1'b0}}, PRIM} << (k-SIZE));
    return p[SIZE-1:0];
  endfunction

  assign horner    = gf_mul(acc_q, x_q) ^ coef_q[idx_q];
  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign y         = y_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    coef_d      = coef_q;
    x_d         = x_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          coef_d  = flat_p;
          x_d     = x;
          acc_d   = flat_p[n*SIZE +: SIZE];
          idx_d   = IW'(n-1);
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = horner;
        if (idx_q == '0) begin
          y_d         = horner;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        // Hand-off returns to IDLE; the next accept is at least one cycle later.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      coef_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      coef_q      <= coef_d;
      x_q         <= x_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_gf_poly_eval.sv
// Bench for gf_poly_eval: directed vectors, random jobs against a sum-of-powers model,
// back-pressure, mid-job reset and back-to-back hand-off timing.
module tb_gf_poly_eval;
  localparam int SIZE = 8;
  localparam int N    = 2;
  localparam int FW   = (N+1)*SIZE;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [FW-1:0]   flat_p;
  logic [SIZE-1:0] x;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] y;

  int checks   = 0;
  int failures = 0;

  gf_poly_eval #(.m(255), .SIZE(SIZE), .n(N), .flat_size(FW), .PRIM(9'h11D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .flat_p(flat_p), .x(x), .out_valid(out_valid), .out_ready(out_ready), .y(y)
  );

  always #5 clk = ~clk;

  // Shift-and-add GF(2^8) multiply, reduction by x^8 = x^4+x^3+x^2+1.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, aa, bb;
    logic       c;
    r = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) r = r ^ aa;
      bb = bb >> 1;
      c  = aa[7];
      aa = aa << 1;
      if (c) aa = aa ^ 8'h1D;
    end
    return r;
  endfunction

  // p(x) = sum c_i * x^i, evaluated directly from powers of x.
  function automatic logic [7:0] ref_eval(input logic [FW-1:0] f, input logic [7:0] xv);
    logic [7:0] s, pw;
    s = 8'h00; pw = 8'h01;
    for (int i = 0; i <= N; i++) begin
      s  = s ^ ref_mul(f[i*SIZE +: SIZE], pw);
      pw = ref_mul(pw, xv);
    end
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flat_p = '0; x = '0;
    step(); step();
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== 8'h00) begin
      failures++;
      $display("FAIL reset: in_ready=%b out_valid=%b y=%h, need 1 0 00", in_ready, out_valid, y);
    end
  endtask

  // One job: accept, latency, result, optional back-pressure with input churn, hand-off.
  task automatic run_job(input logic [FW-1:0] f, input logic [7:0] xv,
                         input logic [7:0] exp_y, input int bp, input string nm);
    int cnt;
    flat_p = f; x = xv; in_valid = 1'b1; out_ready = (bp == 0);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL %s ready_pre: got %b need 1", nm, in_ready);
    end
    step();
    in_valid = 1'b0;
    flat_p = FW'($urandom); x = 8'($urandom);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL %s ready_drop: got %b need 0", nm, in_ready);
    end
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 20) begin
      step(); cnt++;
    end
    checks++;
    if (cnt !== N) begin
      failures++; $display("FAIL %s latency: got %0d edges need %0d", nm, cnt, N);
    end
    checks++;
    if (y !== exp_y) begin
      failures++; $display("FAIL %s y: got %h need %h", nm, y, exp_y);
    end
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'b1; flat_p = FW'($urandom); x = 8'($urandom);
      step();
      checks++;
      if (out_valid !== 1'b1 || y !== exp_y || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s hold%0d: out_valid=%b y=%h in_ready=%b need 1 %h 0",
                 nm, i, out_valid, y, in_ready, exp_y);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s handoff: out_valid=%b in_ready=%b need 0 1", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_directed();
    run_job(24'h040105, 8'h02, 8'h17, 0, "x02");
    run_job(24'h040105, 8'h80, 8'hC9, 0, "x80_prim");
    run_job(24'h040105, 8'h00, 8'h05, 0, "x00");
    run_job(24'h040105, 8'h01, 8'h00, 0, "x01");
    run_job(24'h040105 ^ 24'h020003, 8'h01, 8'h01, 0, "chained");
  endtask

  task automatic test_backpressure();
    run_job(24'h040105, 8'h02, 8'h17, 3, "backpressure");
  endtask

  task automatic test_random();
    logic [FW-1:0] f;
    logic [7:0]    xv;
    for (int k = 0; k < 25; k++) begin
      f  = FW'($urandom);
      xv = 8'($urandom);
      if (k == 0) xv = 8'h00;
      if (k == 1) xv = 8'h01;
      if (k == 2) xv = 8'hFF;
      run_job(f, xv, ref_eval(f, xv), int'($urandom_range(0, 2)), $sformatf("rand%0d", k));
    end
  endtask

  task automatic test_reset_mid_calc();
    flat_p = 24'h040105; x = 8'h02; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid: in_ready=%b out_valid=%b y=%h need 1 0 00", in_ready, out_valid, y);
    end
    step(); step();
    checks++;
    if (out_valid !== 1'b0 || y !== 8'h00) begin
      failures++; $display("FAIL rst_mid_partial: out_valid=%b y=%h need 0 00", out_valid, y);
    end
    run_job(24'h040105, 8'h80, 8'hC9, 0, "after_rst");
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] fb;
    logic [7:0]    xb, yb;
    logic          ov [1:8];
    logic          ir [1:8];
    logic [7:0]    yy [1:8];
    fb = FW'($urandom); xb = 8'($urandom); yb = ref_eval(fb, xb);
    flat_p = 24'h040105; x = 8'h02; in_valid = 1'b1; out_ready = 1'b1;
    step();
    flat_p = fb; x = xb;
    for (int c = 1; c <= 8; c++) begin
      step();
      ov[c] = out_valid; ir[c] = in_ready; yy[c] = y;
      if (c == 4) in_valid = 1'b0;
    end
    checks++;
    if (ov[2] !== 1'b1 || yy[2] !== 8'h17) begin
      failures++; $display("FAIL b2b_first: out_valid=%b y=%h need 1 17", ov[2], yy[2]);
    end
    checks++;
    if (ov[3] !== 1'b0 || ir[3] !== 1'b1) begin
      failures++; $display("FAIL b2b_gap: out_valid=%b in_ready=%b need 0 1", ov[3], ir[3]);
    end
    checks++;
    if (ir[4] !== 1'b0) begin
      failures++; $display("FAIL b2b_accept: in_ready=%b need 0", ir[4]);
    end
    checks++;
    if (ov[5] !== 1'b0 || ov[6] !== 1'b1 || yy[6] !== yb) begin
      failures++;
      $display("FAIL b2b_second: ov5=%b ov6=%b y=%h need 0 1 %h", ov[5], ov[6], yy[6], yb);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_calc();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
